pio_edge_capture: RTL and testbench

PIO_EDGE_CAPTURE -- requirements
Module: pio_edge_capture

---
 rtl/pio_edge_capture.sv | 150 +++++++++++++++
 tb/tb_pio_edge_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pio_edge_capture.sv
// Avalon-MM parallel input port that synchronises the inputs, optionally debounces them, and latches selected edges into sticky EDGECAP bits with a masked level interrupt.
// Latency: EDGECAP sets SYNC_STAGES+1 cycles after an in_port change (+DEBOUNCE_CYCLES with the filter); readdata and irq are registered one cycle behind.
// Backpressure: none; the slave accepts every access immediately. Optional filter: define PIO_EDGE_CAPTURE_DEBOUNCE_EN.
module pio_edge_capture #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] wr_bits;
    logic             wr_en;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef PIO_EDGE_CAPTURE_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      db_cnt [WIDTH];
    logic [WIDTH-1:0] db_level;

    // A bit's counter runs only while the synchronised input disagrees with
    // the accepted level; any return to the accepted level restarts the wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_level <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_in[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync_in[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign filt = db_level;
`else
    assign filt = sync_in;
`endif

    // filt is all-zero while reset is held, so clearing filt_d equals loading
    // the filtered value at reset exit: no edge can be seen from reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_d <= '0;
        end else begin
            filt_d <= filt;
        end
    end

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_set = rise;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_set = fall;
        end else begin : g_any
            assign edge_set = rise | fall;
        end
    endgenerate

    assign wr_en    = chipselect & ~write_n;
    assign wr_bits  = writedata[WIDTH-1:0];
    assign edge_clr = (wr_en && address == ADDR_EDGECAP) ? wr_bits : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) begin
                irq_mask <= wr_bits;
            end
            // Set is ORed in after the clear so a coincident edge wins.
            edge_cap <= (edge_cap & ~edge_clr) | edge_set;
            irq      <= |(edge_cap & irq_mask);
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = filt;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_cap;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_pio_edge_capture.sv
// Bench for pio_edge_capture: rising, falling and any-edge instances share one bus and
// input stream and are checked every cycle against a queue-based reference model.
module tb_pio_edge_capture;

    localparam int S = 2;
`ifdef PIO_EDGE_CAPTURE_DEBOUNCE_EN
    localparam int DB   = 16;
    localparam int HOLD = 22;
    localparam int CHG  = 30;
`else
    localparam int DB   = 0;
    localparam int HOLD = 10;
    localparam int CHG  = 6;
`endif
    localparam int E = S + 1 + DB;   // edges from an in_port change to EDGECAP set

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [7:0]       in_port;
    logic [2:0][31:0] rd;
    logic [2:0]       irq_v;

    int tests  = 0;
    int errors = 0;

    // reference model state
    logic [7:0]  hist [$];
    logic [7:0]  m_acc;
    int          run [8];
    logic [7:0]  m_fd;
    logic [7:0]  m_mask [3];
    logic [7:0]  m_cap [3];
    logic [31:0] m_rd [3];
    logic        m_irq [3];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            pio_edge_capture #(
                .WIDTH(8), .EDGE_TYPE(g), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(16)
            ) u_dut (
                .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
                .write_n(write_n), .writedata(writedata), .in_port(in_port),
                .readdata(rd[g]), .irq(irq_v[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one clock: predict from pre-edge inputs, then compare all instances.
    task automatic tick();
        logic [7:0] s_o, f_o, set, clr;
        logic       wr;
        s_o = (hist.size() >= S) ? hist[hist.size()-S] : 8'h00;
`ifdef PIO_EDGE_CAPTURE_DEBOUNCE_EN
        f_o = m_acc;
`else
        f_o = s_o;
`endif
        if (reset) begin
            hist.delete();
            m_acc = '0;
            m_fd  = '0;
            for (int i = 0; i < 8; i++) run[i] = 0;
            for (int k = 0; k < 3; k++) begin
                m_mask[k] = '0; m_cap[k] = '0; m_rd[k] = '0; m_irq[k] = 1'b0;
            end
        end else begin
            wr  = chipselect && !write_n;
            clr = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0:       set = f_o & ~m_fd;
                    1:       set = ~f_o & m_fd;
                    default: set = f_o ^ m_fd;
                endcase
                m_irq[k] = |(m_cap[k] & m_mask[k]);
                case (address)
                    2'd0:    m_rd[k] = {24'h0, f_o};
                    2'd2:    m_rd[k] = {24'h0, m_mask[k]};
                    2'd3:    m_rd[k] = {24'h0, m_cap[k]};
                    default: m_rd[k] = 32'h0;
                endcase
                m_cap[k] = (m_cap[k] & ~clr) | set;
                if (wr && address == 2'd2) m_mask[k] = writedata[7:0];
            end
`ifdef PIO_EDGE_CAPTURE_DEBOUNCE_EN
            // a new level is accepted after DB consecutive disagreeing samples
            for (int i = 0; i < 8; i++) begin
                if (s_o[i] != m_acc[i]) begin
                    run[i]++;
                    if (run[i] == DB) begin
                        m_acc[i] = s_o[i];
                        run[i]   = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
`endif
            m_fd = f_o;
            hist.push_back(in_port);
            if (hist.size() > 8) void'(hist.pop_front());
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rd%0d", k), rd[k], m_rd[k]);
            chk($sformatf("irq%0d", k), {31'b0, irq_v[k]}, {31'b0, m_irq[k]});
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        ticks(3);
        chk("reset_rd", rd[0], 32'h0);
        chk("reset_irq", {31'b0, irq_v[0]}, 32'h0);
        reset = 1'b0;

        // DATA read of a held pattern
        in_port = 8'hA5; address = 2'd0;
        ticks(HOLD);
        chk("data_a5", rd[0], 32'h0000_00A5);

        // rising edge on bit0 with mask, then clear
        in_port = 8'h00; ticks(HOLD);
        bus_write(2'd3, 32'hFF);
        bus_write(2'd2, 32'h01);
        in_port = 8'h01; address = 2'd3;
        ticks(E + 1);
        chk("cap_bit0", rd[0], 32'h01);
        chk("irq_bit0", {31'b0, irq_v[0]}, 32'h1);
        bus_write(2'd3, 32'h01);
        tick();
        chk("cap_cleared", rd[0], 32'h0);
        chk("irq_cleared", {31'b0, irq_v[0]}, 32'h0);

        // set wins over a coincident write-1-clear
        in_port = 8'h09;
        ticks(E - 1);
        bus_write(2'd3, 32'h08);
        tick();
        chk("set_wins", rd[0] & 32'h08, 32'h08);

        // any-edge falling on bit5, unmask afterwards, then reset
        bus_write(2'd2, 32'h00);
        in_port = 8'h29; ticks(E + 2);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h09; address = 2'd3; ticks(E + 2);
        chk("any_fall_cap", rd[2] & 32'h20, 32'h20);
        chk("masked_irq", {31'b0, irq_v[2]}, 32'h0);
        bus_write(2'd2, 32'h20);
        chk("irq_at_write", {31'b0, irq_v[2]}, 32'h0);
        tick();
        chk("irq_unmask", {31'b0, irq_v[2]}, 32'h1);
        reset = 1'b1; tick();
        chk("irq_reset", {31'b0, irq_v[2]}, 32'h0);
        reset = 1'b0; address = 2'd3; tick();
        chk("cap_reset", rd[2], 32'h0);

`ifdef PIO_EDGE_CAPTURE_DEBOUNCE_EN
        // short pulse rejected, long hold accepted
        in_port = 8'h08; ticks(HOLD);
        bus_write(2'd3, 32'hFF);
        address = 2'd0;
        in_port = 8'h09; ticks(10);
        in_port = 8'h08; ticks(25);
        chk("db_short_data", rd[0] & 32'h01, 32'h0);
        address = 2'd3; tick();
        chk("db_short_cap", rd[0] & 32'h01, 32'h0);
        address = 2'd0; in_port = 8'h09; ticks(22);
        chk("db_long_data", rd[0] & 32'h01, 32'h01);
        address = 2'd3; ticks(2);
        chk("db_long_cap", rd[0] & 32'h01, 32'h01);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, CHG) == 0) in_port = 8'($urandom);
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            reset      = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
